// File: rtl/raizing_sound_mailbox_if.sv
// Bus bundle between the 68k/Z80 decode logic (master) and the sound mailbox (slave).
interface raizing_sound_mailbox_if #(
    parameter int DW       = 8,
    parameter int CHANNELS = 2
) ();
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                M68K_WR;
    logic [CW-1:0]       M68K_CH;
    logic [DW-1:0]       M68K_DIN;
    logic [CHANNELS-1:0] M68K_FULL;
    logic [CHANNELS-1:0] M68K_OVF;
    logic                M68K_OVF_CLR;
    logic                WAIT;
    logic                M68K_REPLY_RD;
    logic [DW-1:0]       REPLY;
    logic                REPLY_VALID;
    logic                Z80_RD;
    logic [CW-1:0]       Z80_CH;
    logic [DW-1:0]       Z80_DOUT;
    logic [CHANNELS-1:0] Z80_STATUS;
    logic                Z80_ACK_WR;
    logic [DW-1:0]       Z80_ACK_DIN;
    logic                INTA;
    logic                INT_N;

    modport master (
        output M68K_WR, M68K_CH, M68K_DIN, M68K_OVF_CLR, M68K_REPLY_RD,
        output Z80_RD, Z80_CH, Z80_ACK_WR, Z80_ACK_DIN, INTA,
        input  M68K_FULL, M68K_OVF, WAIT, REPLY, REPLY_VALID,
        input  Z80_DOUT, Z80_STATUS, INT_N
    );

    modport slave (
        input  M68K_WR, M68K_CH, M68K_DIN, M68K_OVF_CLR, M68K_REPLY_RD,
        input  Z80_RD, Z80_CH, Z80_ACK_WR, Z80_ACK_DIN, INTA,
        output M68K_FULL, M68K_OVF, WAIT, REPLY, REPLY_VALID,
        output Z80_DOUT, Z80_STATUS, INT_N
    );
endinterface

// File: rtl/raizing_sound_mailbox.sv
// 68k->Z80 multi-channel command mailbox with Z80 IRQ, 68k WAIT handshake and reply latch.
// Define SOUND_MBOX_LASTVAL_EN to make empty pops return the channel's last popped value.
module raizing_sound_mailbox #(
    parameter int DW       = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                  CLK96,
    input  logic                  RESET96,
    raizing_sound_mailbox_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH) + 1;
    localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DW-1:0]       mem     [CHANNELS][DEPTH];
    logic [PW-1:0]       wr_ptr  [CHANNELS];
    logic [PW-1:0]       rd_ptr  [CHANNELS];
    logic [NW-1:0]       cnt     [CHANNELS];
    logic [NW-1:0]       cnt_nxt [CHANNELS];

    logic [CHANNELS-1:0] push_c;
    logic [CHANNELS-1:0] pop_c;
    logic [CHANNELS-1:0] ovf_c;
    logic [CHANNELS-1:0] full_q;
    logic [CHANNELS-1:0] status_q;
    logic [CHANNELS-1:0] ovf_q;
    logic                push_any;
    logic                pop_hit;
    logic [DW-1:0]       head_data;
    logic [DW-1:0]       miss_data;

    logic [DW-1:0]       dout_q;
    logic                int_n_q;
    logic                wait_q;
    logic [DW-1:0]       reply_q;
    logic                reply_valid_q;

`ifdef SOUND_MBOX_LASTVAL_EN
    logic [DW-1:0]       last_q  [CHANNELS];
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : PW'(p + 1'b1);
    endfunction

    // Pops are resolved first: a full FIFO that is popped this cycle can still accept the push.
    always_comb begin
        pop_c  = '0;
        push_c = '0;
        ovf_c  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pop_c[c] = bus.Z80_RD && (bus.Z80_CH == CW'(c)) && (cnt[c] != '0);
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.M68K_WR && (bus.M68K_CH == CW'(c))) begin
                if ((cnt[c] != CNT_FULL) || pop_c[c]) begin
                    push_c[c] = 1'b1;
                end else begin
                    ovf_c[c] = 1'b1;
                end
            end
        end
        push_any = |push_c;
        pop_hit  = |pop_c;
    end

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            cnt_nxt[c] = cnt[c];
            if (push_c[c] && !pop_c[c]) begin
                cnt_nxt[c] = cnt[c] + 1'b1;
            end else if (!push_c[c] && pop_c[c]) begin
                cnt_nxt[c] = cnt[c] - 1'b1;
            end
        end
    end

    always_comb begin
        head_data = '1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (pop_c[c]) begin
                head_data = mem[c][rd_ptr[c]];
            end
        end
    end

`ifdef SOUND_MBOX_LASTVAL_EN
    always_comb begin
        miss_data = '1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.Z80_CH == CW'(c)) begin
                miss_data = last_q[c];
            end
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                last_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (pop_c[c]) begin
                    last_q[c] <= mem[c][rd_ptr[c]];
                end
            end
        end
    end
`else
    assign miss_data = '1;
`endif

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge CLK96) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (push_c[c]) begin
                mem[c][wr_ptr[c]] <= bus.M68K_DIN;
            end
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            full_q   <= '0;
            status_q <= '0;
            ovf_q    <= '0;
            dout_q   <= '1;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (push_c[c]) begin
                    wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                end
                if (pop_c[c]) begin
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                end
                cnt[c]      <= cnt_nxt[c];
                full_q[c]   <= (cnt_nxt[c] == CNT_FULL);
                status_q[c] <= (cnt_nxt[c] != '0);
            end
            ovf_q <= bus.M68K_OVF_CLR ? ovf_c : (ovf_q | ovf_c);
            if (pop_hit) begin
                dout_q <= head_data;
            end else if (bus.Z80_RD) begin
                dout_q <= miss_data;
            end
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            int_n_q       <= 1'b1;
            wait_q        <= 1'b0;
            reply_q       <= '0;
            reply_valid_q <= 1'b0;
        end else begin
            if (push_any) begin
                int_n_q <= 1'b0;
            end else if (bus.INTA) begin
                int_n_q <= 1'b1;
            end
            if (push_any) begin
                wait_q <= 1'b1;
            end else if (bus.Z80_ACK_WR) begin
                wait_q <= 1'b0;
            end
            if (bus.Z80_ACK_WR) begin
                reply_q       <= bus.Z80_ACK_DIN;
                reply_valid_q <= 1'b1;
            end else if (bus.M68K_REPLY_RD) begin
                reply_valid_q <= 1'b0;
            end
        end
    end

    assign bus.M68K_FULL   = full_q;
    assign bus.M68K_OVF    = ovf_q;
    assign bus.Z80_STATUS  = status_q;
    assign bus.Z80_DOUT    = dout_q;
    assign bus.INT_N       = int_n_q;
    assign bus.WAIT        = wait_q;
    assign bus.REPLY       = reply_q;
    assign bus.REPLY_VALID = reply_valid_q;
endmodule

// File: tb/tb_raizing_sound_mailbox.sv
// Directed self-checking bench for raizing_sound_mailbox (DW=8, CHANNELS=2, DEPTH=4).
module tb_raizing_sound_mailbox;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    raizing_sound_mailbox_if #(.DW(8), .CHANNELS(2)) bus ();

    raizing_sound_mailbox #(.DW(8), .CHANNELS(2), .DEPTH(4)) dut (
        .CLK96   (clk),
        .RESET96 (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SOUND_MBOX_LASTVAL_EN
    localparam bit LASTVAL = 1'b1;
`else
    localparam bit LASTVAL = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ch, input logic [7:0] d);
        bus.M68K_CH  = ch;
        bus.M68K_DIN = d;
        bus.M68K_WR  = 1'b1;
        tick();
        bus.M68K_WR  = 1'b0;
    endtask

    task automatic pop(input logic ch);
        bus.Z80_CH = ch;
        bus.Z80_RD = 1'b1;
        tick();
        bus.Z80_RD = 1'b0;
    endtask

    task automatic settle();
        bus.INTA = 1'b1;
        tick();
        bus.INTA = 1'b0;
        bus.Z80_ACK_WR = 1'b1;
        tick();
        bus.Z80_ACK_WR = 1'b0;
        bus.M68K_REPLY_RD = 1'b1;
        tick();
        bus.M68K_REPLY_RD = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.Z80_STATUS !== 2'b00) begin n_err++; $display("FAIL reset_status got=%b exp=00", bus.Z80_STATUS); end
        n_cmp++; if (bus.M68K_FULL !== 2'b00) begin n_err++; $display("FAIL reset_full got=%b exp=00", bus.M68K_FULL); end
        n_cmp++; if (bus.M68K_OVF !== 2'b00) begin n_err++; $display("FAIL reset_ovf got=%b exp=00", bus.M68K_OVF); end
        n_cmp++; if (bus.INT_N !== 1'b1) begin n_err++; $display("FAIL reset_int_n got=%b exp=1", bus.INT_N); end
        n_cmp++; if (bus.WAIT !== 1'b0) begin n_err++; $display("FAIL reset_wait got=%b exp=0", bus.WAIT); end
        n_cmp++; if (bus.REPLY !== 8'h00) begin n_err++; $display("FAIL reset_reply got=%h exp=00", bus.REPLY); end
        n_cmp++; if (bus.REPLY_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.REPLY_VALID); end
        n_cmp++; if (bus.Z80_DOUT !== 8'hFF) begin n_err++; $display("FAIL reset_dout got=%h exp=ff", bus.Z80_DOUT); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        push(1'b0, 8'h11);
        n_cmp++; if (bus.Z80_STATUS !== 2'b01) begin n_err++; $display("FAIL order_status1 got=%b exp=01", bus.Z80_STATUS); end
        push(1'b0, 8'h22);
        push(1'b0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            pop(1'b0);
            n_cmp++; if (bus.Z80_DOUT !== exp_d[i]) begin n_err++; $display("FAIL order_pop%0d got=%h exp=%h", i, bus.Z80_DOUT, exp_d[i]); end
        end
        n_cmp++; if (bus.Z80_STATUS !== 2'b00) begin n_err++; $display("FAIL order_status_empty got=%b exp=00", bus.Z80_STATUS); end
        settle();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d [4];
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) begin
            push(1'b1, exp_d[i]);
            if (i == 2) begin
                n_cmp++; if (bus.M68K_FULL !== 2'b00) begin n_err++; $display("FAIL ovf_full3 got=%b exp=00", bus.M68K_FULL); end
            end
        end
        n_cmp++; if (bus.M68K_FULL !== 2'b10) begin n_err++; $display("FAIL ovf_full4 got=%b exp=10", bus.M68K_FULL); end
        bus.Z80_ACK_WR = 1'b1;
        tick();
        bus.Z80_ACK_WR = 1'b0;
        push(1'b1, 8'hA5);
        n_cmp++; if (bus.M68K_OVF !== 2'b10) begin n_err++; $display("FAIL ovf_set got=%b exp=10", bus.M68K_OVF); end
        n_cmp++; if (bus.WAIT !== 1'b0) begin n_err++; $display("FAIL ovf_wait_untouched got=%b exp=0", bus.WAIT); end
        for (int i = 0; i < 4; i++) begin
            pop(1'b1);
            n_cmp++; if (bus.Z80_DOUT !== exp_d[i]) begin n_err++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.Z80_DOUT, exp_d[i]); end
            if (i == 0) begin
                n_cmp++; if (bus.M68K_FULL !== 2'b00) begin n_err++; $display("FAIL ovf_full_after_pop got=%b exp=00", bus.M68K_FULL); end
            end
        end
        n_cmp++; if (bus.M68K_OVF !== 2'b10) begin n_err++; $display("FAIL ovf_sticky got=%b exp=10", bus.M68K_OVF); end
        bus.M68K_OVF_CLR = 1'b1;
        tick();
        bus.M68K_OVF_CLR = 1'b0;
        n_cmp++; if (bus.M68K_OVF !== 2'b00) begin n_err++; $display("FAIL ovf_clr got=%b exp=00", bus.M68K_OVF); end
        // overflow coinciding with clear keeps the flag set
        for (int i = 0; i < 4; i++) push(1'b1, 8'hB0);
        bus.M68K_OVF_CLR = 1'b1;
        push(1'b1, 8'hB9);
        bus.M68K_OVF_CLR = 1'b0;
        n_cmp++; if (bus.M68K_OVF !== 2'b10) begin n_err++; $display("FAIL ovf_set_wins got=%b exp=10", bus.M68K_OVF); end
        for (int i = 0; i < 4; i++) pop(1'b1);
        bus.M68K_OVF_CLR = 1'b1;
        tick();
        bus.M68K_OVF_CLR = 1'b0;
        settle();
    endtask

    task automatic test_irq_handshake();
        push(1'b0, 8'hA5);
        n_cmp++; if (bus.INT_N !== 1'b0) begin n_err++; $display("FAIL irq_int_low got=%b exp=0", bus.INT_N); end
        n_cmp++; if (bus.WAIT !== 1'b1) begin n_err++; $display("FAIL irq_wait_set got=%b exp=1", bus.WAIT); end
        bus.INTA = 1'b1;
        tick();
        tick();
        bus.INTA = 1'b0;
        n_cmp++; if (bus.INT_N !== 1'b1) begin n_err++; $display("FAIL irq_inta_clear got=%b exp=1", bus.INT_N); end
        n_cmp++; if (bus.WAIT !== 1'b1) begin n_err++; $display("FAIL irq_wait_hold got=%b exp=1", bus.WAIT); end
        bus.Z80_ACK_DIN = 8'h5A;
        bus.Z80_ACK_WR  = 1'b1;
        tick();
        bus.Z80_ACK_WR  = 1'b0;
        n_cmp++; if (bus.WAIT !== 1'b0) begin n_err++; $display("FAIL irq_wait_ack got=%b exp=0", bus.WAIT); end
        n_cmp++; if (bus.REPLY !== 8'h5A) begin n_err++; $display("FAIL irq_reply got=%h exp=5a", bus.REPLY); end
        n_cmp++; if (bus.REPLY_VALID !== 1'b1) begin n_err++; $display("FAIL irq_valid_set got=%b exp=1", bus.REPLY_VALID); end
        bus.M68K_REPLY_RD = 1'b1;
        tick();
        bus.M68K_REPLY_RD = 1'b0;
        n_cmp++; if (bus.REPLY_VALID !== 1'b0) begin n_err++; $display("FAIL irq_valid_clr got=%b exp=0", bus.REPLY_VALID); end
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== 8'hA5) begin n_err++; $display("FAIL irq_pop got=%h exp=a5", bus.Z80_DOUT); end
        push(1'b0, 8'hB6);
        pop(1'b0);
        n_cmp++; if (bus.INT_N !== 1'b0) begin n_err++; $display("FAIL irq_pop_keeps_pending got=%b exp=0", bus.INT_N); end
        bus.INTA = 1'b1;
        push(1'b0, 8'hC7);
        n_cmp++; if (bus.INT_N !== 1'b0) begin n_err++; $display("FAIL irq_set_wins got=%b exp=0", bus.INT_N); end
        tick();
        bus.INTA = 1'b0;
        n_cmp++; if (bus.INT_N !== 1'b1) begin n_err++; $display("FAIL irq_inta_after got=%b exp=1", bus.INT_N); end
        pop(1'b0);
        bus.Z80_ACK_WR = 1'b1;
        tick();
        bus.Z80_ACK_WR = 1'b0;
        // push, ack and reply read all in one cycle
        bus.Z80_ACK_DIN   = 8'h3C;
        bus.Z80_ACK_WR    = 1'b1;
        bus.M68K_REPLY_RD = 1'b1;
        push(1'b0, 8'hD8);
        bus.Z80_ACK_WR    = 1'b0;
        bus.M68K_REPLY_RD = 1'b0;
        n_cmp++; if (bus.WAIT !== 1'b1) begin n_err++; $display("FAIL wait_set_wins got=%b exp=1", bus.WAIT); end
        n_cmp++; if (bus.REPLY !== 8'h3C) begin n_err++; $display("FAIL reply_new got=%h exp=3c", bus.REPLY); end
        n_cmp++; if (bus.REPLY_VALID !== 1'b1) begin n_err++; $display("FAIL valid_load_wins got=%b exp=1", bus.REPLY_VALID); end
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== 8'hD8) begin n_err++; $display("FAIL irq_pop_d8 got=%h exp=d8", bus.Z80_DOUT); end
        settle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h77};
        for (int i = 1; i <= 4; i++) push(1'b0, 8'(i));
        bus.Z80_CH = 1'b0;
        bus.Z80_RD = 1'b1;
        push(1'b0, 8'h77);
        bus.Z80_RD = 1'b0;
        n_cmp++; if (bus.Z80_DOUT !== 8'h01) begin n_err++; $display("FAIL b2b_head got=%h exp=01", bus.Z80_DOUT); end
        n_cmp++; if (bus.M68K_FULL !== 2'b01) begin n_err++; $display("FAIL b2b_full got=%b exp=01", bus.M68K_FULL); end
        n_cmp++; if (bus.M68K_OVF !== 2'b00) begin n_err++; $display("FAIL b2b_ovf got=%b exp=00", bus.M68K_OVF); end
        // pop ch0 while pushing ch1
        bus.Z80_CH = 1'b0;
        bus.Z80_RD = 1'b1;
        push(1'b1, 8'hE1);
        bus.Z80_RD = 1'b0;
        n_cmp++; if (bus.Z80_DOUT !== exp_d[0]) begin n_err++; $display("FAIL b2b_cross_pop got=%h exp=%h", bus.Z80_DOUT, exp_d[0]); end
        n_cmp++; if (bus.Z80_STATUS !== 2'b11) begin n_err++; $display("FAIL b2b_cross_status got=%b exp=11", bus.Z80_STATUS); end
        for (int i = 1; i < 4; i++) begin
            pop(1'b0);
            n_cmp++; if (bus.Z80_DOUT !== exp_d[i]) begin n_err++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, bus.Z80_DOUT, exp_d[i]); end
        end
        pop(1'b1);
        n_cmp++; if (bus.Z80_DOUT !== 8'hE1) begin n_err++; $display("FAIL b2b_ch1 got=%h exp=e1", bus.Z80_DOUT); end
        n_cmp++; if (bus.Z80_STATUS !== 2'b00) begin n_err++; $display("FAIL b2b_empty got=%b exp=00", bus.Z80_STATUS); end
        settle();
    endtask

    task automatic test_empty_pop();
        logic [7:0] miss;
        miss = LASTVAL ? 8'h42 : 8'hFF;
        push(1'b0, 8'h42);
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== 8'h42) begin n_err++; $display("FAIL empty_prime got=%h exp=42", bus.Z80_DOUT); end
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== miss) begin n_err++; $display("FAIL empty_pop got=%h exp=%h", bus.Z80_DOUT, miss); end
        bus.Z80_CH = 1'b0;
        bus.Z80_RD = 1'b1;
        push(1'b0, 8'h99);
        bus.Z80_RD = 1'b0;
        n_cmp++; if (bus.Z80_DOUT !== miss) begin n_err++; $display("FAIL empty_no_bypass got=%h exp=%h", bus.Z80_DOUT, miss); end
        n_cmp++; if (bus.Z80_STATUS !== 2'b01) begin n_err++; $display("FAIL empty_stored got=%b exp=01", bus.Z80_STATUS); end
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== 8'h99) begin n_err++; $display("FAIL empty_then_pop got=%h exp=99", bus.Z80_DOUT); end
        settle();
    endtask

    task automatic test_reset_flush();
        logic [7:0] miss;
        miss = LASTVAL ? 8'h00 : 8'hFF;
        push(1'b0, 8'h10);
        push(1'b0, 8'h20);
        for (int i = 0; i < 4; i++) push(1'b1, 8'h30);
        pop(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.Z80_STATUS !== 2'b00) begin n_err++; $display("FAIL flush_status got=%b exp=00", bus.Z80_STATUS); end
        n_cmp++; if (bus.M68K_FULL !== 2'b00) begin n_err++; $display("FAIL flush_full got=%b exp=00", bus.M68K_FULL); end
        n_cmp++; if (bus.INT_N !== 1'b1) begin n_err++; $display("FAIL flush_int_n got=%b exp=1", bus.INT_N); end
        n_cmp++; if (bus.WAIT !== 1'b0) begin n_err++; $display("FAIL flush_wait got=%b exp=0", bus.WAIT); end
        n_cmp++; if (bus.Z80_DOUT !== 8'hFF) begin n_err++; $display("FAIL flush_dout got=%h exp=ff", bus.Z80_DOUT); end
        pop(1'b0);
        n_cmp++; if (bus.Z80_DOUT !== miss) begin n_err++; $display("FAIL flush_pop got=%h exp=%h", bus.Z80_DOUT, miss); end
        n_cmp++; if (bus.Z80_STATUS !== 2'b00) begin n_err++; $display("FAIL flush_status2 got=%b exp=00", bus.Z80_STATUS); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst               = 1'b1;
        bus.M68K_WR       = 1'b0;
        bus.M68K_CH       = '0;
        bus.M68K_DIN      = '0;
        bus.M68K_OVF_CLR  = 1'b0;
        bus.M68K_REPLY_RD = 1'b0;
        bus.Z80_RD        = 1'b0;
        bus.Z80_CH        = '0;
        bus.Z80_ACK_WR    = 1'b0;
        bus.Z80_ACK_DIN   = '0;
        bus.INTA          = 1'b0;
        test_reset();
        test_fifo_order();
        test_overflow();
        test_irq_handshake();
        test_back_to_back();
        test_empty_pop();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
